// File: rtl/clk_div_pkg.sv
// Shared types and helpers for the programmable multi-channel clock divider.
// The optional odd-divisor 50% duty extension is selected by the
// CLK_DIV_ODD_DUTY50_EN macro inside clk_div_ch.
package clk_div_pkg;

  // Default divisor width; the modules expose DIV_W as a parameter seeded from this.
  localparam int DIV_W_DEF = 8;

  typedef logic [DIV_W_DEF-1:0] div_t;

  // Per-channel run state.
  typedef enum logic [1:0] {
    STOP  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } ch_state_e;

  // High-phase length of a divided period: floor(N/2).
  function automatic logic [31:0] half(input logic [31:0] n);
    return n >> 1;
  endfunction

endpackage

// File: rtl/clk_div_ch.sv
// One divider channel: run/drain/stop FSM, period counter, shadow divisor
// with pending flag, and registered divided-clock / clock-enable outputs.
// Optional macro CLK_DIV_ODD_DUTY50_EN adds a negedge flop that stretches
// the high phase by half a cycle for odd divisors >= 3.
module clk_div_ch
  import clk_div_pkg::*;
#(
  parameter int DIV_W       = DIV_W_DEF,
  parameter int DIV_DEFAULT = 2
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_en,
  input  logic             i_wr,
  input  logic [DIV_W-1:0] i_wr_div,
  output logic             o_pend,
  output logic             o_clk_div,
  output logic             o_clk_en,
  output logic             o_active
);

  localparam logic [DIV_W-1:0] DIV_ONE = DIV_W'(1);
  localparam logic [DIV_W-1:0] DIV_RST = DIV_W'(DIV_DEFAULT);

  ch_state_e        state_q, state_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [DIV_W-1:0] shadow_q, shadow_d;
  logic             pend_q, pend_d;
  logic             clk_div_q, clk_en_q, active_q;

  logic             running;
  logic             div_zero;
  logic             boundary;
  logic             load;
  logic [DIV_W-1:0] div_nxt;
  logic [DIV_W-1:0] high_len;

  assign running  = (state_q != STOP);
  assign div_zero = (div_q == '0);
  // Last cycle of the current period; only meaningful while running with N>=1.
  assign boundary = (cnt_q == (div_q - DIV_ONE));
  // A pending divisor is applied immediately when stopped, otherwise only as
  // a period rolls over, so the period in flight always finishes with its old N.
  assign load     = pend_q & (~running | boundary);
  assign div_nxt  = load ? shadow_q : div_q;
  assign high_len = DIV_W'(half(32'(div_q)));

  // Next-state logic: FSM transitions, counter advance, shadow/pending update.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    div_d    = div_q;
    shadow_d = shadow_q;
    pend_d   = pend_q;

    // Writes are only offered while not pending, so they never collide with a load.
    if (i_wr) begin
      shadow_d = i_wr_div;
      pend_d   = 1'b1;
    end
    if (load) begin
      div_d  = shadow_q;
      pend_d = 1'b0;
    end

    case (state_q)
      STOP: begin
        cnt_d = '0;
        // A zero divisor keeps the channel parked even when enabled.
        if (i_en && (div_nxt != '0)) begin
          state_d = RUN;
        end
      end
      RUN, DRAIN: begin
        cnt_d = boundary ? '0 : (cnt_q + DIV_ONE);
        if (div_zero) begin
          // No period can be active with N=0; park right away.
          state_d = STOP;
          cnt_d   = '0;
        end else if (boundary && (!i_en || (div_nxt == '0))) begin
          // Disabled or switched to N=0: stop exactly at the period end.
          state_d = STOP;
        end else begin
          // Drop to DRAIN when disabled mid-period, resume RUN on re-enable.
          state_d = i_en ? RUN : DRAIN;
        end
      end
      default: begin
        state_d = STOP;
        cnt_d   = '0;
      end
    endcase
  end

  // Control state registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= STOP;
      cnt_q   <= '0;
      div_q   <= DIV_RST;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      pend_q  <= pend_d;
    end
  end

  // Shadow divisor holds data only; it is never read unless pending is set.
  always_ff @(posedge i_clk) begin
    shadow_q <= shadow_d;
  end

  // Registered outputs decoded from the current state and count (1-cycle latency).
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      clk_div_q <= 1'b0;
      clk_en_q  <= 1'b0;
      active_q  <= 1'b0;
    end else begin
      clk_div_q <= running & ~div_zero & (cnt_q < high_len);
      clk_en_q  <= running & ~div_zero & (cnt_q == '0);
      active_q  <= running;
    end
  end

`ifdef CLK_DIV_ODD_DUTY50_EN
  logic odd_ext;
  logic ext_q;

  // Odd and not 1 means odd N >= 3; even N and N=1 are left untouched.
  assign odd_ext = div_q[0] & (div_q != DIV_ONE);

  // Negedge copy of the high phase extends it by half an input clock.
  always_ff @(negedge i_clk) begin
    if (i_rst) begin
      ext_q <= 1'b0;
    end else begin
      ext_q <= clk_div_q & odd_ext;
    end
  end

  assign o_clk_div = clk_div_q | ext_q;
`else
  assign o_clk_div = clk_div_q;
`endif

  assign o_clk_en = clk_en_q;
  assign o_active = active_q;
  assign o_pend   = pend_q;

endmodule

// File: rtl/clk_div_prog.sv
// Multi-channel runtime-programmable clock divider top level.
// Instantiates NUM_CH clk_div_ch channels and steers the shared divisor
// write port to the addressed channel with a valid/ready handshake.
// Optional macro CLK_DIV_ODD_DUTY50_EN is handled inside clk_div_ch.
module clk_div_prog
  import clk_div_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int DIV_W       = DIV_W_DEF,
  parameter int DIV_DEFAULT = 2,
  parameter int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [NUM_CH-1:0] i_ch_en,
  input  logic              i_cfg_valid,
  input  logic [CH_W-1:0]   i_cfg_ch,
  input  logic [DIV_W-1:0]  i_cfg_div,
  output logic              o_cfg_ready,
  output logic [NUM_CH-1:0] o_clk_div,
  output logic [NUM_CH-1:0] o_clk_en,
  output logic [NUM_CH-1:0] o_ch_active
);

  localparam logic [CH_W:0] NUM_CH_L = (CH_W + 1)'(NUM_CH);

  logic [NUM_CH-1:0] pend;
  logic [NUM_CH-1:0] wr;
  logic              ch_in_range;
  logic              accept;

  // Indices beyond NUM_CH are accepted and dropped so the port never stalls.
  assign ch_in_range = ({1'b0, i_cfg_ch} < NUM_CH_L);
  assign o_cfg_ready = ch_in_range ? ~pend[i_cfg_ch] : 1'b1;
  assign accept      = i_cfg_valid & o_cfg_ready & ch_in_range;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    assign wr[g] = accept & (i_cfg_ch == CH_W'(g));

    clk_div_ch #(
      .DIV_W       (DIV_W),
      .DIV_DEFAULT (DIV_DEFAULT)
    ) u_ch (
      .i_clk     (i_clk),
      .i_rst     (i_rst),
      .i_en      (i_ch_en[g]),
      .i_wr      (wr[g]),
      .i_wr_div  (i_cfg_div),
      .o_pend    (pend[g]),
      .o_clk_div (o_clk_div[g]),
      .o_clk_en  (o_clk_en[g]),
      .o_active  (o_ch_active[g])
    );
  end

endmodule
